// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time program loader for the single-cycle RISC-V core.
// It takes a byte stream over a valid/ready handshake. The stream starts with a
// 16-bit little-endian word count N, followed by 4N data bytes. Each group of four
// bytes is assembled little-endian into one 32-bit word. Words are written to
// consecutive instruction-memory word addresses starting at BASE_ADDR. The core is
// held in reset until the whole image has been loaded.
//
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing checksum
// byte. The checksum is the XOR of all data bytes. A mismatch ends the load in ERR.
// Words have already been written by the time the checksum is compared.
module instr_mem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CSUM   = 3'd7
`endif
    } state_t;

    // State entered once all words are written, including the N = 0 case.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CSUM;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    // Depth widened to 32 bits so that the length check cannot truncate.
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    state_t       state_reg;
    state_t       state_next;
    logic [7:0]   len_lo_reg;
    logic [15:0]  n_reg;
    logic [1:0]   byte_cnt_reg;
    logic [23:0]  partial_reg;
    logic [31:0]  wr_data_reg;
    logic [15:0]  word_count_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]   csum_reg;
`endif

    logic         accept;
    logic         idle_like;
    logic         load_start;
    logic [15:0]  len_value;
    logic [15:0]  count_inc;

    // A byte is accepted only when the source offers it and the loader is ready.
    // byte_ready is decoded from the state register alone, so it never depends on
    // byte_valid.
    assign accept     = byte_valid & byte_ready;
    assign idle_like  = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR);
    assign load_start = start & idle_like;
    assign len_value  = {byte_data, len_lo_reg};
    assign count_inc  = word_count_reg + 16'd1;

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the loader sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    if ({16'd0, len_value} > DEPTH_U) begin
                        state_next = S_ERR;
                    end else if (len_value == 16'd0) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_cnt_reg == 2'd3)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (count_inc < n_reg) begin
                    state_next = S_DATA;
                end else begin
                    state_next = S_FINISH;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_next = (byte_data == csum_reg) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Output decode. All outputs come straight from the state register.
    always_comb begin
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        core_rst   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_LEN_LO, S_LEN_HI, S_DATA: begin
                byte_ready = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
            end
`endif
            S_WRITE: begin
                wr_en = 1'b1;
            end
            S_DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                core_rst = 1'b1;
            end
            S_ERR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Datapath: length capture, word assembly, word counter and checksum.
    // Every register holds its value while the source stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_lo_reg     <= 8'd0;
            n_reg          <= 16'd0;
            byte_cnt_reg   <= 2'd0;
            partial_reg    <= 24'd0;
            wr_data_reg    <= 32'd0;
            word_count_reg <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg       <= 8'd0;
`endif
        end else if (load_start) begin
            byte_cnt_reg   <= 2'd0;
            word_count_reg <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_reg       <= 8'd0;
`endif
        end else begin
            if ((state_reg == S_LEN_LO) && accept) begin
                len_lo_reg <= byte_data;
            end
            if ((state_reg == S_LEN_HI) && accept) begin
                n_reg <= len_value;
            end
            if ((state_reg == S_DATA) && accept) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum_reg     <= csum_reg ^ byte_data;
`endif
                case (byte_cnt_reg)
                    2'd0:    partial_reg[7:0]   <= byte_data;
                    2'd1:    partial_reg[15:8]  <= byte_data;
                    2'd2:    partial_reg[23:16] <= byte_data;
                    default: wr_data_reg        <= {byte_data, partial_reg};
                endcase
            end
            if (state_reg == S_WRITE) begin
                word_count_reg <= count_inc;
            end
        end
    end

    // The write address follows the word counter. During WRITE the counter still
    // holds the index of the word being written. The sum wraps modulo 2^32.
    assign wr_addr    = BASE_ADDR + {14'd0, word_count_reg, 2'b00};
    assign wr_data    = wr_data_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed testbench for instr_mem_loader.
// Define LOADER_CHECKSUM_EN for both this bench and the RTL to exercise the
// checksum variant.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    instr_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .core_rst(core_rst),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log: every cycle with wr_en is recorded with its address, data and
    // cycle number. It also counts write cycles in which byte_ready was high.
    logic [31:0] log_addr [32];
    logic [31:0] log_data [32];
    int          log_cyc  [32];
    int          nwr = 0;
    int          rdy_viol = 0;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (nwr < 32) begin
                log_addr[nwr] = wr_addr;
                log_data[nwr] = wr_data;
                log_cyc[nwr]  = cyc;
            end
            nwr = nwr + 1;
            if (byte_ready !== 1'b0) rdy_viol = rdy_viol + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one byte and waits for the edge that accepts it. On return the
    // time is 1 after that edge. With gap set, valid is dropped for one cycle.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!acc && t < 50) begin
            acc = (byte_ready === 1'b1);
            @(posedge clk);
            #1;
            t++;
        end
        byte_valid = 1'b0;
        chk("accept_within_budget", {31'd0, acc}, 32'd1);
        if (gap) tick(1);
    endtask

    logic [7:0] seq [$];

    task automatic send_seq(input bit gap);
        foreach (seq[i]) send_byte(seq[i], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    int c0;
    int wbase;
    int vbase;

    initial begin
        // Reset state, with reset held low.
        tick(3);
        chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_wr_en",      {31'd0, wr_en},      32'd0);
        chk("rst_wr_addr",    wr_addr,             32'h0);
        chk("rst_wr_data",    wr_data,             32'h0);
        chk("rst_core_rst",   {31'd0, core_rst},   32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        $display("step reset: checks=%0d errors=%0d", checks, errors);

        // N=2 image with valid held high.
        wbase = nwr;
        pulse_start();
        c0 = cyc;
        chk("t1_busy_after_start",  {31'd0, busy},       32'd1);
        chk("t1_ready_after_start", {31'd0, byte_ready}, 32'd1);
        chk("t1_core_rst_loading",  {31'd0, core_rst},   32'd0);
        seq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        send_seq(1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h30, 1'b0);
`endif
        tick(2);
        chk("t1_num_writes", 32'(nwr - wbase), 32'd2);
        chk("t1_addr0", log_addr[wbase],     32'h0000_0000);
        chk("t1_data0", log_data[wbase],     32'h00A0_0513);
        chk("t1_addr1", log_addr[wbase + 1], 32'h0000_0004);
        chk("t1_data1", log_data[wbase + 1], 32'h0010_0593);
        chk("t1_wr0_latency", 32'(log_cyc[wbase] - c0),     32'd6);
        chk("t1_wr1_latency", 32'(log_cyc[wbase + 1] - c0), 32'd11);
        chk("t1_done",       {31'd0, done},       32'd1);
        chk("t1_core_rst",   {31'd0, core_rst},   32'd1);
        chk("t1_err",        {31'd0, err},        32'd0);
        chk("t1_busy",       {31'd0, busy},       32'd0);
        chk("t1_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("t1_word_count", {16'd0, word_count}, 32'd2);
        chk("t1_wr_data_hold", wr_data, 32'h0010_0593);
        $display("step n2_held_valid: writes=%0d checks=%0d errors=%0d", nwr - wbase, checks, errors);

        // Same image with valid toggling every other cycle.
        wbase = nwr;
        vbase = rdy_viol;
        pulse_start();
        chk("t2_done_cleared",  {31'd0, done},       32'd0);
        chk("t2_core_rst_low",  {31'd0, core_rst},   32'd0);
        chk("t2_count_cleared", {16'd0, word_count}, 32'd0);
        send_seq(1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h30, 1'b1);
`endif
        tick(2);
        chk("t2_num_writes", 32'(nwr - wbase), 32'd2);
        chk("t2_addr0", log_addr[wbase],     32'h0000_0000);
        chk("t2_data0", log_data[wbase],     32'h00A0_0513);
        chk("t2_addr1", log_addr[wbase + 1], 32'h0000_0004);
        chk("t2_data1", log_data[wbase + 1], 32'h0010_0593);
        chk("t2_ready_low_in_write", 32'(rdy_viol - vbase), 32'd0);
        chk("t2_done",       {31'd0, done},       32'd1);
        chk("t2_word_count", {16'd0, word_count}, 32'd2);
        $display("step n2_toggled_valid: writes=%0d checks=%0d errors=%0d", nwr - wbase, checks, errors);

        // Oversized header: N=1025 exceeds DEPTH.
        wbase = nwr;
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h04, 1'b0);
        tick(3);
        chk("t3_err",        {31'd0, err},        32'd1);
        chk("t3_done",       {31'd0, done},       32'd0);
        chk("t3_core_rst",   {31'd0, core_rst},   32'd0);
        chk("t3_byte_ready", {31'd0, byte_ready}, 32'd0);
        chk("t3_busy",       {31'd0, busy},       32'd0);
        chk("t3_no_writes",  32'(nwr - wbase),    32'd0);
        $display("step oversize: err=%0b checks=%0d errors=%0d", err, checks, errors);

        // Empty image: N=0.
        wbase = nwr;
        pulse_start();
        chk("t4_err_cleared", {31'd0, err}, 32'd0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        chk("t4_not_done_before_csum", {31'd0, done}, 32'd0);
        send_byte(8'h00, 1'b0);
`endif
        chk("t4_done",       {31'd0, done},       32'd1);
        chk("t4_core_rst",   {31'd0, core_rst},   32'd1);
        chk("t4_no_writes",  32'(nwr - wbase),    32'd0);
        chk("t4_word_count", {16'd0, word_count}, 32'd0);
        $display("step empty: done=%0b checks=%0d errors=%0d", done, checks, errors);

        // Reset after 6 data bytes of an N=2 load, then a full N=1 load.
        wbase = nwr;
        pulse_start();
        seq = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05};
        send_seq(1'b0);
        chk("t5_writes_before_abort", 32'(nwr - wbase), 32'd1);
        chk("t5_busy_before_abort",   {31'd0, busy},    32'd1);
        rst = 1'b0;
        #2;
        chk("t5_async_busy",       {31'd0, busy},       32'd0);
        chk("t5_async_ready",      {31'd0, byte_ready}, 32'd0);
        chk("t5_async_word_count", {16'd0, word_count}, 32'd0);
        chk("t5_async_wr_data",    wr_data,             32'h0);
        chk("t5_async_wr_addr",    wr_addr,             32'h0);
        tick(2);
        rst = 1'b1;
        tick(1);
        wbase = nwr;
        pulse_start();
        seq = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send_seq(1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB6, 1'b0);
`endif
        tick(2);
        chk("t5_num_writes", 32'(nwr - wbase), 32'd1);
        chk("t5_addr0",      log_addr[wbase],  32'h0000_0000);
        chk("t5_data0",      log_data[wbase],  32'h00A0_0513);
        chk("t5_word_count", {16'd0, word_count}, 32'd1);
        chk("t5_done",       {31'd0, done},       32'd1);
        $display("step abort_reload: writes=%0d checks=%0d errors=%0d", nwr - wbase, checks, errors);

`ifdef LOADER_CHECKSUM_EN
        // Matching checksum.
        wbase = nwr;
        pulse_start();
        seq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        send_seq(1'b0);
        tick(1);
        chk("t6_done",     {31'd0, done}, 32'd1);
        chk("t6_err",      {31'd0, err},  32'd0);
        chk("t6_data0",    log_data[wbase], 32'h0804_0201);
        $display("step csum_good: done=%0b checks=%0d errors=%0d", done, checks, errors);

        // Mismatching checksum.
        wbase = nwr;
        pulse_start();
        seq = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        send_seq(1'b0);
        tick(1);
        chk("t7_err",        {31'd0, err},      32'd1);
        chk("t7_done",       {31'd0, done},     32'd0);
        chk("t7_core_rst",   {31'd0, core_rst}, 32'd0);
        chk("t7_num_writes", 32'(nwr - wbase),  32'd1);
        chk("t7_addr0",      log_addr[wbase],   32'h0000_0000);
        chk("t7_data0",      log_data[wbase],   32'h0804_0201);
        $display("step csum_bad: err=%0b checks=%0d errors=%0d", err, checks, errors);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Boot-time program loader for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into the instruction memory's write port at consecutive word addresses, and holds the core in reset until the image is complete. It is the writer side of the instruction-memory interface that the core's fetch path reads.

## Interface
Parameters:
- DEPTH, 1024: instruction memory size in 32-bit words; maximum image length.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a load
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  32  byte address of the write, word-aligned
- wr_data  out  32  assembled word
- core_rst  out  1  active-low reset to the core; 1 releases the core
- busy  out  1  a load is in progress
- done  out  1  the load completed successfully; sticky
- err  out  1  the load failed; sticky
- word_count  out  16  number of words written in this load

## Operation
- Stream format: LEN_LO, LEN_HI form a 16-bit word count N. It is followed by 4N data bytes, least-significant byte of each word first.
- States:
  - IDLE: no load in progress.
  - LEN_LO, LEN_HI: receive the two bytes of N.
  - DATA: receive data bytes.
  - WRITE: issue the memory write.
  - CSUM: receive the checksum byte; exists only with the checksum feature.
  - DONE: load completed successfully.
  - ERR: load failed.
- Transitions:
  - IDLE, DONE or ERR plus start moves to LEN_LO. This clears done, err and word_count, and drives core_rst to 0.
  - start in any other state is ignored.
  - LEN_LO plus an accepted byte moves to LEN_HI.
  - LEN_HI plus an accepted byte latches N, then:
    - N > DEPTH: go to ERR.
    - N = 0: go to DONE, or to CSUM when the checksum feature is compiled in.
    - otherwise: go to DATA.
  - DATA: a byte counter [1:0] places each byte at bits [8k+7:8k]. The 4th accepted byte moves to WRITE.
  - WRITE:
    - wr_en=1 for exactly one cycle.
    - wr_addr = BASE_ADDR + 4*word_count, computed modulo 2^32.
    - word_count increments.
    - Then go to DATA if word_count < N, otherwise to DONE (or CSUM).
  - DONE: done=1, core_rst=1.
  - ERR: err=1, core_rst stays 0.
- A byte is accepted only on a rising edge with byte_valid && byte_ready.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CSUM.
- busy=1 in every state except IDLE, DONE and ERR.
- wr_data holds its value outside WRITE. wr_en=0 outside WRITE.

## Timing
- Reset values: state=IDLE, byte_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, core_rst=0, busy=0, done=0, err=0, word_count=0.
- Reset asserted mid-load aborts immediately and returns all outputs to reset values. Words already written remain in memory.
- byte_ready is registered from the state and is never combinationally dependent on byte_valid.
- Per word: 4 accept cycles plus 1 WRITE cycle, so 5 cycles minimum. byte_ready=0 during WRITE back-pressures the source.
- With byte_valid held high, wr_en for word i occurs 2 + 5i + 4 cycles after the LEN_LO state is entered.
- core_rst rises on the clock edge that enters DONE, the same edge as done.
- byte_valid stalls are unbounded. The partial word and counters hold their values.

## Configuration
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - After the final word (or straight after LEN_HI when N=0), the CSUM state accepts one byte.
  - The expected value is the XOR of all 4N data bytes. Length bytes are excluded.
  - Match goes to DONE; mismatch goes to ERR.
  - Words are still written before the check completes.
- Undefined: the CSUM state and its XOR accumulator are absent. After the final WRITE the loader goes directly to DONE.

## Test plan
- Load N=2, bytes 02 00 13 05 A0 00 93 05 10 00 with valid held high:
  - wr_en at wr_addr 0x0 with data 0x00A00513, then at 0x4 with data 0x00100593.
  - done=1, core_rst=1, word_count=2.
- Same image with byte_valid toggling every other cycle: identical writes and values; byte_ready=0 in each WRITE cycle.
- Header 01 04 (N=1025 > 1024): err=1, no wr_en ever, core_rst stays 0, byte_ready=0.
- Header 00 00: done=1 after 2 accepted bytes without checksum, or after 3 accepted bytes with checksum byte 00; no wr_en.
- Assert rst after 6 data bytes of an N=2 load, release, pulse start, send a full N=1 image:
  - exactly one write, to 0x0.
  - word_count=1, done=1.
- With LOADER_CHECKSUM_EN defined:
  - N=1 image with data 01 02 04 08 and checksum 0F: done=1.
  - Same image with checksum 0E: err=1, core_rst=0. The word was still written at 0x0.
